// File: rtl/keycode_in_pio.sv
// keycode_in_pio: Avalon-MM parallel input port for key/status lines.
// Synchronizes WIDTH asynchronous inputs and captures any-edge events per bit
// into a sticky, write-1-to-clear register. It raises a level interrupt for
// edge bits that are enabled in the mask register.
//
// Register map (word address):
//   0 : data  (RO)  synchronized input value
//   1 : reserved (reads 0, writes ignored)
//   2 : mask  (RW)  interrupt enable per bit
//   3 : cap   (RO, W1C) sticky edge capture
module keycode_in_pio #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  // Synchronizer and edge-detect state.
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_det;

  // Software-visible registers.
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;

  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Any-edge detect: the synchronized value differs from its one-cycle-old copy.
  assign edge_det = data_reg ^ prev_reg;

  // Clear request for the capture register; only the low WIDTH bits of the
  // write data matter.
  assign cap_clr = (wr_en && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

  // Per-bit capture update. A new edge overrides a simultaneous clear, so an
  // event that arrives while software is acknowledging an older one is not lost.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cap_bit
      assign cap_next[gi] = edge_det[gi] | (cap_reg[gi] & ~cap_clr[gi]);
    end
  endgenerate

  // Mask register next value: it loads only on a write to its own address.
  always_comb begin
    mask_next = mask_reg;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_next = writedata[WIDTH-1:0];
    end
  end

  // Read mux: returns zero when the port is not selected and for the reserved
  // word. Narrow registers are zero-extended to the 32-bit bus.
  always_comb begin
    readdata_next = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata_next = 32'(data_reg);
        ADDR_RSVD: readdata_next = '0;
        ADDR_MASK: readdata_next = 32'(mask_reg);
        ADDR_CAP:  readdata_next = 32'(cap_reg);
        default:   readdata_next = '0;
      endcase
    end
  end

  // Two-flop synchronizer plus the previous-value copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      data_reg  <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= in_port;
      data_reg  <= sync1_reg;
      prev_reg  <= data_reg;
    end
  end

  // Capture and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_reg  <= '0;
      mask_reg <= '0;
    end else begin
      cap_reg  <= cap_next;
      mask_reg <= mask_next;
    end
  end

  // Registered read data, which gives one cycle of read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else begin
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;

  // The interrupt level comes straight from the registers, with no added latency.
  assign irq = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_keycode_in_pio.sv
// Testbench for keycode_in_pio: directed scenarios plus randomized bus and
// input traffic, checked against a behavioural model of the port.
module tb_keycode_in_pio;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '0;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model. The data register shows the input sampled two clocks
  // earlier. An edge is any difference between that sample and the one before it.
  logic [7:0]  hist_m [3];   // hist_m[0] holds the newest sampled input
  logic [7:0]  cap_m;
  logic [7:0]  mask_m;
  logic [31:0] rd_m;
  logic [7:0]  cur_in;

  keycode_in_pio #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist_m[i] = '0;
    cap_m  = '0;
    mask_m = '0;
    rd_m   = '0;
  endtask

  // Applies one clock edge to the model, using the bus inputs presented at that edge.
  task automatic model_step(input logic [7:0] in, input logic [1:0] a, input logic cs,
                            input logic wr, input logic [31:0] wd);
    logic [7:0] seen;
    logic [7:0] changed;
    seen    = hist_m[1];
    changed = hist_m[1] ^ hist_m[2];
    if (!cs)          rd_m = '0;
    else if (a == 0)  rd_m = {24'd0, seen};
    else if (a == 2)  rd_m = {24'd0, mask_m};
    else if (a == 3)  rd_m = {24'd0, cap_m};
    else              rd_m = '0;
    if (cs && wr && a == 2'd3) cap_m = cap_m & ~wd[7:0];
    cap_m = cap_m | changed;
    if (cs && wr && a == 2'd2) mask_m = wd[7:0];
    hist_m[2] = hist_m[1];
    hist_m[1] = hist_m[0];
    hist_m[0] = in;
  endtask

  // One bus cycle. It starts and ends on a falling edge.
  task automatic cycle(input logic [7:0] in, input logic [1:0] a, input logic cs,
                       input logic wr, input logic [31:0] wd);
    in_port    = in;
    address    = a;
    chipselect = cs;
    write_n    = ~wr;
    writedata  = wd;
    cur_in     = in;
    @(posedge clk);
    model_step(in, a, cs, wr, wd);
    #1;
    $display("t=%0t in=%02h a=%0d cs=%0b wr=%0b wd=%08h rd=%08h irq=%0b",
             $time, in, a, cs, wr, wd, readdata, irq);
    check("readdata", readdata, rd_m);
    check("irq", {31'd0, irq}, {31'd0, |(cap_m & mask_m)});
    @(negedge clk);
  endtask

  // Pulses reset mid-cycle while a cap clear write is being presented. The
  // task leaves the design out of reset on a falling edge, with in_port = in.
  task automatic do_reset(input logic [7:0] in);
    in_port    = in;
    cur_in     = in;
    chipselect = 1'b1;
    address    = 2'd3;
    write_n    = 1'b0;
    writedata  = 32'hFFFF_FFFF;
    #2;
    reset_n = 1'b0;
    #1;
    $display("t=%0t reset asserted, in=%02h rd=%08h irq=%0b", $time, in, readdata, irq);
    check("rst_async_rd", readdata, 32'd0);
    check("rst_async_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_rd", readdata, 32'd0);
    check("rst_hold_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0]  r_in;
    logic [1:0]  r_a;
    logic        r_cs;
    logic        r_wr;
    logic [31:0] r_wd;

    model_reset();
    cur_in = '0;

    // Reset held: every address reads zero, and writes are ignored.
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      address    = 2'(a);
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      $display("t=%0t reset held, a=%0d rd=%08h irq=%0b", $time, a, readdata, irq);
      check("reset_rd", readdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
    end
    reset_n = 1'b1;

    // Data path: the input appears in the data register after synchronization.
    repeat (4) cycle(8'h5A, 2'd0, 1'b1, 1'b0, 32'd0);
    check("data_5a", readdata, 32'h0000_005A);

    // Clear the start-up edges, then enable only bit 0.
    cycle(8'h5A, 2'd3, 1'b1, 1'b1, 32'h0000_00FF);
    cycle(8'h5A, 2'd2, 1'b1, 1'b1, 32'h0000_0001);
    cycle(8'h5A, 2'd3, 1'b1, 1'b0, 32'd0);
    check("cap_cleared", readdata, 32'd0);

    // Toggle bit 0 (enabled), then bit 1 (masked).
    repeat (4) cycle(8'h5B, 2'd0, 1'b0, 1'b0, 32'd0);
    check("irq_bit0", {31'd0, irq}, 32'd1);
    cycle(8'h5B, 2'd3, 1'b1, 1'b0, 32'd0);
    check("cap_01", readdata, 32'h01);
    repeat (4) cycle(8'h59, 2'd0, 1'b0, 1'b0, 32'd0);
    check("irq_bit1_masked", {31'd0, irq}, 32'd1);
    cycle(8'h59, 2'd3, 1'b1, 1'b0, 32'd0);
    check("cap_03", readdata, 32'h03);

    // Write-1-to-clear behaviour.
    cycle(8'h59, 2'd3, 1'b1, 1'b1, 32'h01);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    cycle(8'h59, 2'd3, 1'b1, 1'b0, 32'd0);
    check("w1c_cap_02", readdata, 32'h02);
    cycle(8'h59, 2'd3, 1'b1, 1'b1, 32'h00);
    cycle(8'h59, 2'd3, 1'b1, 1'b0, 32'd0);
    check("w0_cap_02", readdata, 32'h02);

    // Collision: the bit 2 edge reaches the detector on the clear's edge.
    cycle(8'h5D, 2'd0, 1'b0, 1'b0, 32'd0);
    cycle(8'h5D, 2'd0, 1'b0, 1'b0, 32'd0);
    cycle(8'h5D, 2'd3, 1'b1, 1'b1, 32'h04);
    cycle(8'h5D, 2'd3, 1'b1, 1'b0, 32'd0);
    check("collision_cap2", readdata & 32'h04, 32'h04);

    // Reset mid-operation, with everything captured and enabled.
    cycle(8'h5D, 2'd2, 1'b1, 1'b1, 32'hFF);
    repeat (4) cycle(8'hA2, 2'd0, 1'b0, 1'b0, 32'd0);
    cycle(8'hA2, 2'd3, 1'b1, 1'b0, 32'd0);
    check("cap_ff", readdata, 32'hFF);
    check("irq_before_rst", {31'd0, irq}, 32'd1);
    do_reset(8'h00);
    for (int a = 0; a < 4; a++) begin
      cycle(8'h00, 2'(a), 1'b1, 1'b0, 32'd0);
      check("post_rst_zero", readdata, 32'd0);
    end

    // Randomized traffic, including occasional resets with inputs high.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(8'($urandom));
      end else begin
        r_in = cur_in;
        if ($urandom_range(0, 3) == 0) r_in = cur_in ^ 8'($urandom);
        r_a  = 2'($urandom);
        r_cs = ($urandom_range(0, 3) != 0);
        r_wr = ($urandom_range(0, 2) == 0);
        r_wd = $urandom;
        cycle(r_in, r_a, r_cs, r_wr, r_wd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
